// File: rtl/sar_scan_controller_if.sv
// Bundle of channel-request, SAR core and result-handshake signals for
// sar_scan_controller. The master modport is the controller's view.
interface sar_scan_if #(
    parameter int NCH = 4
);
    localparam int CHW = (NCH > 1) ? $clog2(NCH) : 1;

    logic [NCH-1:0] req;
    logic [CHW-1:0] mux_sel;
    logic           sample_en;
    logic           sar_rst;
    logic [11:0]    sar_bits;
    logic           sar_done;
    logic [11:0]    res_data;
    logic [CHW-1:0] res_ch;
    logic           res_err;
    logic           res_valid;
    logic           res_ready;
    logic           busy;

    modport master (
        input  req, sar_bits, sar_done, res_ready,
        output mux_sel, sample_en, sar_rst, res_data, res_ch, res_err,
               res_valid, busy
    );

    modport slave (
        output req, sar_bits, sar_done, res_ready,
        input  mux_sel, sample_en, sar_rst, res_data, res_ch, res_err,
               res_valid, busy
    );
endinterface

// File: rtl/sar_scan_controller.sv
// Round-robin multi-channel scheduler for the 12-bit SAR core: collects
// channel requests, then runs mux settle, sample/hold, conversion with
// timeout, and delivers each tagged result on a valid/ready handshake.
module sar_scan_controller #(
    parameter int NCH           = 4,
    parameter int SETTLE_CYCLES = 2,
    parameter int SAMPLE_CYCLES = 4,
    parameter int TIMEOUT       = 20
) (
    input  logic      clk,
    input  logic      rst_n,
    sar_scan_if.master bus
);
    localparam int CHW = (NCH > 1) ? $clog2(NCH) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETTLE,
        S_SAMPLE,
        S_CONVERT,
        S_OUTPUT
    } state_t;

    state_t         state, state_d;
    logic [7:0]     cnt, cnt_d;
    logic [NCH-1:0] pending, pending_d, clr;
    logic [CHW-1:0] last_grant, last_grant_d;
    logic [CHW-1:0] mux_sel, mux_sel_d;
    logic           sample_en, sample_en_d;
    logic           sar_rst, sar_rst_d;
    logic [11:0]    res_data, res_data_d;
    logic [CHW-1:0] res_ch, res_ch_d;
    logic           res_err, res_err_d;
    logic           res_valid, res_valid_d;
    logic           busy, busy_d;

    logic           found;
    logic [CHW-1:0] winner;
    logic [CHW:0]   sum;

    // Round-robin search starting one past the last granted channel.
    always_comb begin
        found  = 1'b0;
        winner = '0;
        sum    = '0;
        for (int unsigned i = 1; i <= NCH; i++) begin
            sum = {1'b0, last_grant} + (CHW+1)'(i);
            if (sum >= (CHW+1)'(NCH)) sum = sum - (CHW+1)'(NCH);
            if (!found && pending[sum[CHW-1:0]]) begin
                found  = 1'b1;
                winner = sum[CHW-1:0];
            end
        end
    end

    // Next-state and next-output logic; every output is registered below.
    always_comb begin
        state_d      = state;
        cnt_d        = cnt;
        clr          = '0;
        last_grant_d = last_grant;
        mux_sel_d    = mux_sel;
        sample_en_d  = 1'b0;
        sar_rst_d    = 1'b1;
        res_data_d   = res_data;
        res_ch_d     = res_ch;
        res_err_d    = res_err;
        res_valid_d  = 1'b0;

        case (state)
            S_IDLE: begin
                if (found) begin
                    clr[winner]  = 1'b1;
                    last_grant_d = winner;
                    mux_sel_d    = winner;
                    cnt_d        = 8'(SETTLE_CYCLES - 1);
                    state_d      = S_SETTLE;
                end
            end
            S_SETTLE: begin
                if (cnt == '0) begin
                    state_d     = S_SAMPLE;
                    cnt_d       = 8'(SAMPLE_CYCLES - 1);
                    sample_en_d = 1'b1;
                end else begin
                    cnt_d = cnt - 8'd1;
                end
            end
            S_SAMPLE: begin
                if (cnt == '0) begin
                    state_d   = S_CONVERT;
                    cnt_d     = 8'(TIMEOUT - 1);
                    sar_rst_d = 1'b0;
                end else begin
                    cnt_d       = cnt - 8'd1;
                    sample_en_d = 1'b1;
                end
            end
            S_CONVERT: begin
                if (bus.sar_done) begin
                    res_data_d  = bus.sar_bits;
                    res_ch_d    = mux_sel;
                    res_err_d   = 1'b0;
                    res_valid_d = 1'b1;
                    state_d     = S_OUTPUT;
                end else if (cnt == '0) begin
                    res_data_d  = '0;
                    res_ch_d    = mux_sel;
                    res_err_d   = 1'b1;
                    res_valid_d = 1'b1;
                    state_d     = S_OUTPUT;
                end else begin
                    cnt_d     = cnt - 8'd1;
                    sar_rst_d = 1'b0;
                end
            end
            S_OUTPUT: begin
                if (bus.res_ready) begin
                    state_d = S_IDLE;
                end else begin
                    res_valid_d = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // A request arriving on the grant cycle re-arms the channel.
        pending_d = (pending & ~clr) | bus.req;
        busy_d    = (state_d != S_IDLE);
    end

    // State and registered outputs with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            cnt        <= '0;
            pending    <= '0;
            last_grant <= CHW'(NCH - 1);
            mux_sel    <= '0;
            sample_en  <= 1'b0;
            sar_rst    <= 1'b1;
            res_data   <= '0;
            res_ch     <= '0;
            res_err    <= 1'b0;
            res_valid  <= 1'b0;
            busy       <= 1'b0;
        end else begin
            state      <= state_d;
            cnt        <= cnt_d;
            pending    <= pending_d;
            last_grant <= last_grant_d;
            mux_sel    <= mux_sel_d;
            sample_en  <= sample_en_d;
            sar_rst    <= sar_rst_d;
            res_data   <= res_data_d;
            res_ch     <= res_ch_d;
            res_err    <= res_err_d;
            res_valid  <= res_valid_d;
            busy       <= busy_d;
        end
    end

    assign bus.mux_sel   = mux_sel;
    assign bus.sample_en = sample_en;
    assign bus.sar_rst   = sar_rst;
    assign bus.res_data  = res_data;
    assign bus.res_ch    = res_ch;
    assign bus.res_err   = res_err;
    assign bus.res_valid = res_valid;
    assign bus.busy      = busy;
endmodule

// File: tb/tb_sar_scan_controller.sv
// Self-checking bench for sar_scan_controller (NCH=4, defaults) with a
// behavioural SAR core that answers 14 cycles after sar_rst falls.
module tb_sar_scan_controller;
    logic clk;
    logic rst_n;
    bit   sar_ok;
    int   mcnt;
    int   n_checks;
    int   n_fail;

    sar_scan_if #(.NCH(4)) bus ();

    sar_scan_controller #(
        .NCH(4), .SETTLE_CYCLES(2), .SAMPLE_CYCLES(4), .TIMEOUT(20)
    ) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  req;
        logic [11:0] bits;
        bit          ok;
        int          ch;
        int          data;
        int          err;
        int          lat;
        int          low;
    } vec_t;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    task automatic reset_dut();
        bus.req = '0;
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    task automatic wait_valid(input int limit, output int k, output bit got);
        k = 0;
        got = 1'b0;
        while (!got && k < limit) begin
            tick();
            k++;
            if (bus.res_valid) got = 1'b1;
        end
    endtask

    // SAR core model: sar_done pulses in the 14th cycle of sar_rst low.
    initial begin
        mcnt = 0;
        bus.sar_done = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (bus.sar_rst === 1'b0) mcnt++;
            else mcnt = 0;
            bus.sar_done = sar_ok && (mcnt == 14);
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs[5];
        int   rr_a[6];
        int   rr_b[4];
        int   k, n, se, low, muxbad, busy_seen;
        bit   got;

        n_checks = 0;
        n_fail   = 0;
        sar_ok   = 1'b1;
        bus.req       = '0;
        bus.sar_bits  = '0;
        bus.res_ready = 1'b1;

        vecs[0] = '{4'b0100, 12'hA5C, 1'b1, 2, 'hA5C, 0, 22, 14};
        vecs[1] = '{4'b0001, 12'h3C7, 1'b1, 0, 'h3C7, 0, 22, 14};
        vecs[2] = '{4'b1000, 12'hFFF, 1'b1, 3, 'hFFF, 0, 22, 14};
        vecs[3] = '{4'b0010, 12'h5A5, 1'b0, 1, 'h000, 1, 28, 20};
        vecs[4] = '{4'b0100, 12'h000, 1'b1, 2, 'h000, 0, 22, 14};
        rr_a = '{0, 1, 2, 3, 0, 1};
        rr_b = '{0, 2, 0, 2};

        // Reset values
        rst_n = 1'b0;
        tick();
        tick();
        chk("rst_mux_sel",   int'(bus.mux_sel),   0);
        chk("rst_sample_en", int'(bus.sample_en), 0);
        chk("rst_sar_rst",   int'(bus.sar_rst),   1);
        chk("rst_res_data",  int'(bus.res_data),  0);
        chk("rst_res_ch",    int'(bus.res_ch),    0);
        chk("rst_res_err",   int'(bus.res_err),   0);
        chk("rst_res_valid", int'(bus.res_valid), 0);
        chk("rst_busy",      int'(bus.busy),      0);
        chk("rst_pending",   int'(dut.pending),   0);
        rst_n = 1'b1;
        tick();

        // Table-driven single-request conversions, including a timeout
        for (int v = 0; v < 5; v++) begin
            bus.sar_bits = vecs[v].bits;
            sar_ok = vecs[v].ok;
            bus.req = vecs[v].req;
            k = 0; got = 1'b0; se = 0; low = 0; muxbad = 0;
            while (!got && k < 60) begin
                tick();
                k++;
                if (k == 1) bus.req = '0;
                if (bus.sample_en) se++;
                if (!bus.sar_rst) low++;
                if (bus.busy && !bus.res_valid && int'(bus.mux_sel) != vecs[v].ch) muxbad++;
                if (bus.res_valid) got = 1'b1;
            end
            chk($sformatf("v%0d_valid_seen", v), int'(got), 1);
            chk($sformatf("v%0d_latency", v), k, vecs[v].lat);
            chk($sformatf("v%0d_res_data", v), int'(bus.res_data), vecs[v].data);
            chk($sformatf("v%0d_res_ch", v), int'(bus.res_ch), vecs[v].ch);
            chk($sformatf("v%0d_res_err", v), int'(bus.res_err), vecs[v].err);
            chk($sformatf("v%0d_sample_cycles", v), se, 4);
            chk($sformatf("v%0d_sar_rst_low", v), low, vecs[v].low);
            chk($sformatf("v%0d_mux_hold", v), muxbad, 0);
            chk($sformatf("v%0d_sar_rst_back", v), int'(bus.sar_rst), 1);
            tick();
            chk($sformatf("v%0d_valid_drop", v), int'(bus.res_valid), 0);
            tick();
        end
        sar_ok = 1'b1;

        // Round-robin with all channels requesting
        reset_dut();
        bus.res_ready = 1'b1;
        bus.req = 4'b1111;
        n = 0; k = 0;
        while (n < 6 && k < 300) begin
            tick();
            k++;
            if (bus.res_valid) begin
                chk($sformatf("rr_a_%0d", n), int'(bus.res_ch), rr_a[n]);
                n++;
            end
        end
        chk("rr_a_count", n, 6);

        reset_dut();
        bus.req = 4'b0101;
        n = 0; k = 0;
        while (n < 4 && k < 200) begin
            tick();
            k++;
            if (bus.res_valid) begin
                chk($sformatf("rr_b_%0d", n), int'(bus.res_ch), rr_b[n]);
                n++;
            end
        end
        chk("rr_b_count", n, 4);

        // Backpressure: result held for 10 cycles, next grant waits
        reset_dut();
        bus.res_ready = 1'b0;
        bus.sar_bits = 12'h6B1;
        bus.req = 4'b0010;
        tick();
        bus.req = 4'b1000;
        tick();
        bus.req = '0;
        wait_valid(40, k, got);
        chk("bp_valid_seen", int'(got), 1);
        bus.sar_bits = 12'h0F0;
        for (int i = 0; i < 10; i++) begin
            chk($sformatf("bp_hold_%0d", i),
                int'(bus.res_valid && bus.res_data == 12'h6B1 && bus.res_ch == 2'd1
                     && bus.busy && bus.mux_sel == 2'd1), 1);
            if (i < 9) tick();
        end
        bus.res_ready = 1'b1;
        tick();
        chk("bp_release_valid", int'(bus.res_valid), 0);
        chk("bp_release_idle",  int'(bus.busy), 0);
        chk("bp_release_mux",   int'(bus.mux_sel), 1);
        tick();
        chk("bp_next_grant_busy", int'(bus.busy), 1);
        chk("bp_next_grant_mux",  int'(bus.mux_sel), 3);
        wait_valid(40, k, got);
        chk("bp_second_valid", int'(got), 1);
        chk("bp_second_ch",   int'(bus.res_ch), 3);
        chk("bp_second_data", int'(bus.res_data), 'h0F0);

        // Set/clear collision on the grant cycle, then reset mid-SAMPLE
        reset_dut();
        bus.sar_bits = 12'h123;
        bus.req = 4'b0010;
        tick();
        chk("col_pending_set", int'(dut.pending[1]), 1);
        tick();
        bus.req = '0;
        chk("col_granted", int'(bus.busy && bus.mux_sel == 2'd1), 1);
        chk("col_set_wins", int'(dut.pending[1]), 1);
        wait_valid(40, k, got);
        chk("col_first_valid", int'(got), 1);
        chk("col_first_ch", int'(bus.res_ch), 1);
        k = 0;
        while (!bus.sample_en && k < 40) begin
            tick();
            k++;
        end
        chk("col_second_sample", int'(bus.sample_en), 1);
        chk("col_second_ch", int'(bus.mux_sel), 1);
        bus.req = 4'b1000;
        tick();
        bus.req = '0;
        chk("mid_pending_before", int'(dut.pending[3]), 1);
        chk("mid_still_sampling", int'(bus.sample_en), 1);
        rst_n = 1'b0;
        tick();
        chk("mid_rst_sar_rst",   int'(bus.sar_rst), 1);
        chk("mid_rst_sample_en", int'(bus.sample_en), 0);
        chk("mid_rst_res_valid", int'(bus.res_valid), 0);
        chk("mid_rst_pending",   int'(dut.pending), 0);
        chk("mid_rst_busy",      int'(bus.busy), 0);
        rst_n = 1'b1;
        busy_seen = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (bus.busy) busy_seen++;
        end
        chk("mid_rst_no_restart", busy_seen, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
